reg_scoreboard: RTL

//  Read-side companion to the general register file: tracks in-flight writes to each of the 32 GPRs.

---
 rtl/scoreboard_pkg.sv | 23 ++
 rtl/sb_entry.sv | 41 ++++
 rtl/reg_scoreboard.sv | 104 ++++++++++
 3 files changed

// File: rtl/scoreboard_pkg.sv
// Shared types and helpers for the register scoreboard (reg_scoreboard, sb_entry).
package scoreboard_pkg;

  localparam int REG_NUM = 32;
  localparam int REG_AW  = 5;
  localparam int LAT_W   = 3;
  localparam int CNT_W   = 6;

  typedef logic [REG_AW-1:0] reg_idx_t;
  typedef logic [LAT_W-1:0]  lat_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  function automatic logic [CNT_W-1:0] popcount(input logic [REG_NUM-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      c = c + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/sb_entry.sv
// One per-register latency countdown: load wins over clear, otherwise counts down to zero.
module sb_entry
  import scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LAT_W-1:0] load_lat,
  input  logic             clear,
  output logic [LAT_W-1:0] cnt,
  output logic             busy,
  output logic             busy_next
);

  lat_t cnt_q;
  lat_t cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_lat;
    end else if (clear) begin
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - lat_t'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt       = cnt_q;
  assign busy      = (cnt_q != '0);
  assign busy_next = (cnt_d != '0);

endmodule

// File: rtl/reg_scoreboard.sv
// GPR in-flight write scoreboard: decode stall generation, per-register countdowns, busy popcount.
// Optional macro REG_SCOREBOARD_FWD_EN: a source with one cycle left is forwardable, so not a read hazard.
module reg_scoreboard
  import scoreboard_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_AW-1:0]   rs,
  input  logic [REG_AW-1:0]   rt,
  input  logic                use_rs,
  input  logic                use_rt,
  input  logic                issue_valid,
  input  logic [REG_AW-1:0]   issue_rd,
  input  logic [LAT_W-1:0]    issue_lat,
  input  logic                wb_valid,
  input  logic [REG_AW-1:0]   wb_rd,
  output logic                stall,
  output logic [REG_NUM-1:0]  busy_mask,
  output logic [CNT_W-1:0]    busy_count
);

  lat_t                 cnt_w [REG_NUM];
  logic [REG_NUM-1:0]   busy_w;
  logic [REG_NUM-1:0]   busy_next_w;
  logic [REG_NUM-1:0]   rd_busy;
  logic [REG_NUM-1:1]   load_w;
  logic [REG_NUM-1:1]   clear_w;
  logic                 issue_accept;
  logic [CNT_W-1:0]     busy_count_q;
  logic [CNT_W-1:0]     busy_count_d;

  // $0 is hardwired: never counted, never busy.
  assign cnt_w[0]       = '0;
  assign busy_w[0]      = 1'b0;
  assign busy_next_w[0] = 1'b0;

  for (genvar r = 1; r < REG_NUM; r++) begin : g_entry
    sb_entry u_entry (
      .clk       (clk),
      .reset     (reset),
      .load      (load_w[r]),
      .load_lat  (issue_lat),
      .clear     (clear_w[r]),
      .cnt       (cnt_w[r]),
      .busy      (busy_w[r]),
      .busy_next (busy_next_w[r])
    );
  end

  // Reader hazard view; the WAW check always uses the plain busy bit.
  always_comb begin
    rd_busy = '0;
    for (int r = 0; r < REG_NUM; r++) begin
`ifdef REG_SCOREBOARD_FWD_EN
      rd_busy[r] = (cnt_w[r] > lat_t'(1));
`else
      rd_busy[r] = (cnt_w[r] != '0);
`endif
    end
  end

  always_comb begin
    stall = 1'b0;
    if (use_rs && rd_busy[rs] && (rs != REG_ZERO)) begin
      stall = 1'b1;
    end
    if (use_rt && rd_busy[rt] && (rt != REG_ZERO)) begin
      stall = 1'b1;
    end
    if (issue_valid && busy_w[issue_rd] && (issue_rd != REG_ZERO)) begin
      stall = 1'b1;
    end
  end

  // A zero latency is not a legal issue and leaves the entry on its normal countdown.
  assign issue_accept = issue_valid && !stall && (issue_rd != REG_ZERO)
                        && (issue_lat != '0);

  always_comb begin
    load_w  = '0;
    clear_w = '0;
    for (int r = 1; r < REG_NUM; r++) begin
      load_w[r]  = issue_accept && (issue_rd == reg_idx_t'(r));
      clear_w[r] = wb_valid && (wb_rd == reg_idx_t'(r));
    end
  end

  // Count the post-edge mask so busy_count lines up with busy_mask.
  always_comb begin
    busy_count_d = popcount(busy_next_w);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_count_q <= '0;
    end else begin
      busy_count_q <= busy_count_d;
    end
  end

  assign busy_mask  = busy_w;
  assign busy_count = busy_count_q;

endmodule
